// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, pipeline stall hints and the shared memory port.
// The slave view belongs to the arbiter; the master view belongs to requesters and memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        acc_err;
  logic        if_stall;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, acc_err, if_stall, mem_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, acc_err, if_stall, mem_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port; data wins unless the
// fetch side has been passed over STARVE_MAX times in a row. Stuck accesses time out.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t        r_state, w_next;
  logic          w_grant_i, w_grant_d, w_done, w_tmo;
  logic [SW-1:0] r_starve;
  logic [7:0]    r_tmo;
  logic          r_mem_req, r_mem_we, r_if_ack, r_d_ack, r_acc_err;
  logic [31:0]   r_mem_addr, r_mem_wdata, r_if_rdata, r_d_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Completion beats timeout when both land in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && r_starve == SW'(STARVE_MAX))) begin
          w_next    = GRANT_D;
          w_grant_d = 1'b1;
        end else if (bus.if_req) begin
          w_next    = GRANT_I;
          w_grant_i = 1'b1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_ack) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (r_tmo == 8'(TIMEOUT - 1)) begin
          w_next = IDLE;
          w_tmo  = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve    <= '0;
      r_tmo       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_acc_err   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_d_ack   <= 1'b0;
      r_acc_err <= 1'b0;

      if (w_grant_i) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= bus.if_addr;
        r_tmo      <= '0;
        r_starve   <= '0;
      end

      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.d_we;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_tmo       <= '0;
        if (!bus.if_req)
          r_starve <= '0;
        else if (r_starve != SW'(STARVE_MAX))
          r_starve <= r_starve + SW'(1);
      end

      if (w_done || w_tmo) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        r_acc_err <= w_tmo;
        // Aborted accesses return zero data so a stale word is never mistaken for a result.
        if (r_state == GRANT_I) begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_done ? bus.mem_rdata : 32'h0;
        end else begin
          r_d_ack    <= 1'b1;
          r_d_rdata  <= w_done ? bus.mem_rdata : 32'h0;
        end
      end else if (r_state != IDLE) begin
        r_tmo <= r_tmo + 8'd1;
      end
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.acc_err   = r_acc_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_stall  = bus.if_req & ~r_if_ack;
  assign bus.mem_stall = bus.d_req  & ~r_d_ack;
endmodule
